jtgng_prog_resp: RTL

//  Responder side of the SDRAM programming port (prog_addr/prog_rd/prog_we/prog_mask/prog_data -> sdram_ack/data_ok/sdram_dout).
//  It is a BRAM-backed stand-in for the SDRAM controller's programming path, used by post-download converters in

---
 rtl/jtgng_prog_resp.sv | 117 +++++++++++
 1 files changed

// File: rtl/jtgng_prog_resp.sv
// BRAM-backed responder for the SDRAM programming port: request/ack/data_ok handshake
// with a fixed access latency and periodic refresh stalls that block new requests.
module jtgng_prog_resp #(
    parameter int MW          = 12,
    parameter int LAT         = 3,
    parameter int RFSH_PERIOD = 64,
    parameter int RFSH_LEN    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    input  logic        prog_we,
    input  logic        prog_rd,
    output logic        sdram_ack,
    output logic        data_ok,
    output logic [15:0] sdram_dout,
    output logic        rfsh_busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RFSH = 2'd2} state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [7:0]      rcnt_q, rcnt_d;
    logic            rfsh_pend_q, rfsh_pend_d;
    logic [MW-1:0]   addr_q;
    logic [7:0]      data_q;
    logic [1:0]      mask_q;
    logic            we_q;
    logic [15:0]     dout_q;
    logic [15:0]     rd_q;
    logic [15:0]     mem [0:(1<<MW)-1];
    logic [MW-1:0]   rd_addr;
    logic            wrap, done, commit;
    logic            unused_addr;

    assign unused_addr = ^prog_addr[21:MW];

    assign wrap      = (rcnt_q == 8'(RFSH_PERIOD-1));
    assign sdram_ack = !rst && (state_q == IDLE) && !rfsh_pend_q && (prog_we || prog_rd);
    assign done      = !rst && (state_q == BUSY) && (cnt_q == 4'd0);
    assign data_ok   = done;
    assign commit    = done && we_q;
    assign rfsh_busy = (state_q == RFSH);

    // The BRAM port looks at the incoming address while idle so that read data is
    // already registered in the completion cycle, even with LAT=1.
    assign rd_addr    = (state_q == IDLE) ? prog_addr[MW-1:0] : addr_q;
    assign sdram_dout = (done && !we_q) ? rd_q : dout_q;

    always_comb begin
        rcnt_d      = rcnt_q + 8'd1;
        rfsh_pend_d = rfsh_pend_q;
        if (wrap) begin
            rcnt_d      = 8'd0;
            rfsh_pend_d = 1'b1;
        end else if (state_q == IDLE && rfsh_pend_q) begin
            rfsh_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rcnt_q      <= 8'd0;
            rfsh_pend_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= 8'd0;
            mask_q      <= 2'b11;
            we_q        <= 1'b0;
            dout_q      <= 16'd0;
        end else begin
            rcnt_q      <= rcnt_d;
            rfsh_pend_q <= rfsh_pend_d;
            case (state_q)
                IDLE: begin
                    if (rfsh_pend_q) begin
                        state_q <= RFSH;
                        cnt_q   <= 4'(RFSH_LEN-1);
                    end else if (sdram_ack) begin
                        state_q <= BUSY;
                        cnt_q   <= 4'(LAT-1);
                        addr_q  <= prog_addr[MW-1:0];
                        data_q  <= prog_data;
                        mask_q  <= prog_mask;
                        we_q    <= prog_we;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        if (!we_q) dout_q <= rd_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RFSH: begin
                    if (cnt_q == 4'd0) state_q <= IDLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte-lane writes commit only on the completion edge; mask bits are active low.
    always_ff @(posedge clk) begin
        rd_q <= mem[rd_addr];
        if (commit) begin
            for (int i = 0; i < 2; i++) begin
                if (!mask_q[i]) mem[addr_q][i*8 +: 8] <= data_q;
            end
        end
    end
endmodule
